md5_compress_iter: RTL and testbench

Iterative MD5 compression core: accepts one 512-bit message block plus a 128-bit chaining value and runs all 64 MD5 steps (four rounds) on one shared datapath. It then adds the chaining value and returns the updated 128-bit hash. It succeeds the single-round, fixed-16-step computation block in the MD5 design. It generalises that block to a parametrised number of steps per clock, adds internal round sequencing, an IV-select mode and valid/ready handshakes on both sides.

---
 rtl/md5_compress_iter.sv | 106 ++++++++++
 tb/tb_md5_compress_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/md5_compress_iter.sv
// md5_compress_iter: iterative MD5 block compression with STEPS steps per clock and valid/ready handshakes
module md5_compress_iter #(
  parameter int STEPS = 1,
  parameter int n = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         init_i,
  input  logic [n-1:0] H_i [0:3],
  input  logic [n-1:0] M_i [0:15],
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [n-1:0] H_o [0:3],
  output logic         busy_o
);
  if (!(STEPS == 1 || STEPS == 2 || STEPS == 4 || STEPS == 8 || STEPS == 16) || n != 32) begin : g_bad
    $error("md5_compress_iter: STEPS must be 1/2/4/8/16 and n must be 32");
  end
  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam logic [4:0] S [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };
  localparam logic [31:0] IV [4] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       st_q;
  logic [6:0]   i_q;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [n-1:0] hs_q [4];
  logic [n-1:0] m_q [16];
  logic [n-1:0] h_sel [4];
  logic [127:0] abcd_d;
  function automatic logic [3:0] g_of(input logic [5:0] j);
    g_of = j[5:4] == 2'd0 ? j[3:0] :
           j[5:4] == 2'd1 ? 4'(5 * j[3:0] + 1) :
           j[5:4] == 2'd2 ? 4'(3 * j[3:0] + 5) : 4'(7 * j[3:0]);
  endfunction
  function automatic logic [127:0] md5_step(input logic [127:0] x, input logic [5:0] j, input logic [31:0] w);
    logic [31:0] a, b, c, d, f, t, rot;
    logic [4:0]  sh;
    {a, b, c, d} = x;
    f = j[5:4] == 2'd0 ? (b & c) | (~b & d) :
        j[5:4] == 2'd1 ? (b & d) | (c & ~d) :
        j[5:4] == 2'd2 ? b ^ c ^ d : c ^ (b | ~d);
    t = a + f + K[j] + w;
    sh = S[{j[5:4], j[1:0]}];
    rot = (t << sh) | (t >> (6'd32 - {1'b0, sh}));
    md5_step = {d, b + rot, b, c};
  endfunction
  // STEPS steps chained combinationally from the current working registers
  always_comb begin
    abcd_d = {a_q, b_q, c_q, d_q};
    for (int s = 0; s < STEPS; s++)
      abcd_d = md5_step(abcd_d, i_q[5:0] + 6'(s), m_q[g_of(i_q[5:0] + 6'(s))]);
  end
  always_comb begin
    for (int k = 0; k < 4; k++) h_sel[k] = init_i ? IV[k] : H_i[k];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st_q <= IDLE;
      i_q <= '0;
      {a_q, b_q, c_q, d_q} <= '0;
      hs_q <= '{default: '0};
      m_q <= '{default: '0};
      H_o <= '{default: '0};
    end else begin
      case (st_q)
        IDLE: if (in_valid_i) begin
          m_q <= M_i;
          hs_q <= h_sel;
          {a_q, b_q, c_q, d_q} <= {h_sel[0], h_sel[1], h_sel[2], h_sel[3]};
          i_q <= '0;
          st_q <= RUN;
        end
        RUN: begin
          {a_q, b_q, c_q, d_q} <= abcd_d;
          i_q <= i_q + 7'(STEPS);
          if (i_q + 7'(STEPS) == 7'd64) begin
            H_o[0] <= hs_q[0] + abcd_d[127:96];
            H_o[1] <= hs_q[1] + abcd_d[95:64];
            H_o[2] <= hs_q[2] + abcd_d[63:32];
            H_o[3] <= hs_q[3] + abcd_d[31:0];
            st_q <= DONE;
          end
        end
        DONE: if (out_ready_i) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o  = st_q == IDLE;
  assign busy_o      = st_q == RUN;
  assign out_valid_o = st_q == DONE;
endmodule

// File: tb/tb_md5_compress_iter.sv
// tb_md5_compress_iter: RFC 1321 digests at STEPS=1/4/16, plus chaining, backpressure, reset and throughput
module tb_md5_compress_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b1;
  logic [31:0] H [0:3];
  logic [31:0] M [0:15];
  logic [2:0]  in_valid, out_ready;
  logic        ir1, ov1, bz1, ir4, ov4, bz4, ir16, ov16, bz16;
  logic [31:0] ho1 [0:3];
  logic [31:0] ho4 [0:3];
  logic [31:0] ho16 [0:3];
  int          n_chk = 0, n_fail = 0;
  localparam logic [127:0] CHAIN = 128'h07ef1582_ca0ba296_d316e1aa_4a666c87;
  always #5 clk = ~clk;
  md5_compress_iter #(.STEPS(1)) dut1 (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(ir1),
    .init_i(init), .H_i(H), .M_i(M), .out_valid_o(ov1), .out_ready_i(out_ready[0]), .H_o(ho1), .busy_o(bz1));
  md5_compress_iter #(.STEPS(4)) dut4 (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(ir4),
    .init_i(init), .H_i(H), .M_i(M), .out_valid_o(ov4), .out_ready_i(out_ready[1]), .H_o(ho4), .busy_o(bz4));
  md5_compress_iter #(.STEPS(16)) dut16 (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(ir16),
    .init_i(init), .H_i(H), .M_i(M), .out_valid_o(ov16), .out_ready_i(out_ready[2]), .H_o(ho16), .busy_o(bz16));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] hash_of(input int d);
    return d == 0 ? {ho1[0], ho1[1], ho1[2], ho1[3]} :
           d == 1 ? {ho4[0], ho4[1], ho4[2], ho4[3]} : {ho16[0], ho16[1], ho16[2], ho16[3]};
  endfunction
  // {in_ready, out_valid, busy}
  function automatic logic [127:0] flags_of(input int d);
    return d == 0 ? 128'({ir1, ov1, bz1}) : d == 1 ? 128'({ir4, ov4, bz4}) : 128'({ir16, ov16, bz16});
  endfunction
  function automatic logic ov_of(input int d);
    return d == 0 ? ov1 : d == 1 ? ov4 : ov16;
  endfunction
  function automatic logic [127:0] exp_of(input int v);
    return v == 0 ? 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec :
           v == 1 ? 128'h98500190_b04fd23c_7d3f96d6_727fe128 :
           v == 2 ? 128'hb975c10c_a8b6f1c0_e299c331_61267769 :
           v == 3 ? 128'h7d696bf9_8d93b77c_312f5a52_d061f1aa : 128'hd7d3fcc3_00e49261_6c49fb7d_3be167ca;
  endfunction
  // 0 "", 1 "abc", 2 "a", 3 "message digest", 4 a..z, 5/6 the two blocks of "abcdbcde...nopq"
  task automatic set_msg(input int v);
    foreach (M[j]) M[j] = '0;
    case (v)
      0: M[0] = 32'h00000080;
      1: begin M[0] = 32'h80636261; M[14] = 32'h18; end
      2: begin M[0] = 32'h00008061; M[14] = 32'h8; end
      3: begin
        M[0] = 32'h7373656d; M[1] = 32'h20656761; M[2] = 32'h65676964; M[3] = 32'h00807473; M[14] = 32'h70;
      end
      4: begin
        M[0] = 32'h64636261; M[1] = 32'h68676665; M[2] = 32'h6c6b6a69; M[3] = 32'h706f6e6d;
        M[4] = 32'h74737271; M[5] = 32'h78777675; M[6] = 32'h00807a79; M[14] = 32'hd0;
      end
      5: begin
        for (int j = 0; j < 14; j++) M[j] = {8'(100 + j), 8'(99 + j), 8'(98 + j), 8'(97 + j)};
        M[14] = 32'h80;
      end
      default: M[14] = 32'h1c0;
    endcase
  endtask
  task automatic set_h(input logic [127:0] h);
    for (int k = 0; k < 4; k++) H[k] = h[127 - 32 * k -: 32];
  endtask
  task automatic start(input int d);
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask
  task automatic wait_done(input int d, input string tag, input int lat_exp);
    int lat = 0;
    while (!ov_of(d) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(tag, 128'(lat), 128'(lat_exp));
  endtask
  task automatic take(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [127:0] h1;
    int acc_t [8];
    int nacc, ndone, cyc, bz_cnt;
    logic pb;
    in_valid = '0;
    out_ready = '0;
    set_h('0);
    set_msg(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags1", flags_of(0), 128'(3'b100));
    chk("rst_h1", hash_of(0), '0);
    chk("rst_flags16", flags_of(2), 128'(3'b100));
    rst = 1'b1;
    set_h({4{32'hdeadbeef}});
    start(0);
    wait_done(0, "empty_lat", 64);
    chk("empty_h", hash_of(0), exp_of(0));
    take(0);
    chk("idle_after_take", flags_of(0), 128'(3'b100));
    set_msg(1);
    for (int d = 0; d < 3; d++) begin
      start(d);
      wait_done(d, "abc_lat", 64 >> (2 * d));
      chk("abc_h", hash_of(d), exp_of(1));
      take(d);
    end
    for (int d = 0; d < 3; d++) begin
      init = 1'b1;
      set_msg(5);
      start(d);
      wait_done(d, "chain1_lat", 64 >> (2 * d));
      h1 = hash_of(d);
      take(d);
      init = 1'b0;
      set_h(h1);
      set_msg(6);
      start(d);
      wait_done(d, "chain2_lat", 64 >> (2 * d));
      chk("chain_h", hash_of(d), CHAIN);
      take(d);
    end
    init = 1'b1;
    set_msg(1);
    start(0);
    wait_done(0, "bp_lat", 64);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin set_msg(3); in_valid[0] = 1'b1; end
      if (c == 6) in_valid[0] = 1'b0;
      @(posedge clk); #1;
      chk("bp_flags", flags_of(0), 128'(3'b010));
      chk("bp_h", hash_of(0), exp_of(1));
    end
    take(0);
    chk("bp_release", flags_of(0), 128'(3'b100));
    set_msg(1);
    start(0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_run", flags_of(0), 128'(3'b001));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_run_flags", flags_of(0), 128'(3'b100));
    chk("rst_run_h", hash_of(0), '0);
    rst = 1'b1;
    start(0);
    wait_done(0, "post_rst_lat", 64);
    chk("post_rst_h", hash_of(0), exp_of(1));
    take(0);
    nacc = 0; ndone = 0; cyc = 0; bz_cnt = 0; pb = 1'b0;
    set_msg(0);
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    while (ndone < 8 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (bz1) bz_cnt++;
      if (bz1 && !pb && nacc < 8) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc == 8) in_valid[0] = 1'b0;
        else set_msg(nacc % 5);
      end
      if (ov1) begin
        chk("b2b_h", hash_of(0), exp_of(ndone % 5));
        ndone++;
      end
      pb = bz1;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    chk("b2b_count", 128'(ndone), 128'd8);
    chk("b2b_busy", 128'(bz_cnt), 128'd512);
    for (int k = 1; k < nacc; k++) chk("b2b_period", 128'(acc_t[k] - acc_t[k-1]), 128'd66);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
